// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port slice: default bus widths,
// arbiter state encoding and master index constants.
package cpu_mem_pkg;

    localparam int ADDR_LEN_DEFAULT = 14;
    localparam int DATA_W_DEFAULT   = 32;

    // Arbiter ownership state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Master indices into the request/grant vectors.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage : cpu_mem_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two master request ports, the shared read-data return and
// the single RAM port that the arbiter drives.
interface mem_port_arbiter_if
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT
);

    // M0: CPU core
    logic                m0_req;
    logic                m0_we;
    logic [ADDR_LEN-1:0] m0_addr;
    logic [DATA_W-1:0]   m0_wdata;
    logic                m0_lock;
    logic                m0_gnt;
    logic                m0_rvalid;

    // M1: program loader / debug port
    logic                m1_req;
    logic                m1_we;
    logic [ADDR_LEN-1:0] m1_addr;
    logic [DATA_W-1:0]   m1_wdata;
    logic                m1_lock;
    logic                m1_gnt;
    logic                m1_rvalid;

    // Shared read data, qualified by mX_rvalid
    logic [DATA_W-1:0]   rdata;

    // RAM port
    logic                ram_we;
    logic [ADDR_LEN-1:0] ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    // Both bus masters, seen from their side.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_rvalid,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid,
        input  rdata
    );

    // The arbiter: accepts master requests and drives the RAM port.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_rvalid,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid,
        output rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    // The RAM itself.
    modport ram (
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_rr_lock_arb.sv
// Two-way round-robin arbiter with a bounded ownership lock. Holds the
// ownership state, the last winner and the consecutive-lock counter, and
// produces a one-hot-or-zero grant combinationally from req/lock.
module rr_lock_arb
    import cpu_mem_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    localparam logic [8:0] MAX_HOLD_W = 9'(MAX_HOLD);

    arb_state_t state, state_nxt;
    logic       last_gnt, last_gnt_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [8:0] hold_inc;
    logic       hold_ok;

    assign hold_inc = {1'b0, hold_cnt} + 9'd1;
    assign hold_ok  = ({1'b0, hold_cnt} < MAX_HOLD_W);

    // State register: ownership, last winner and lock counter.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            state    <= IDLE;
            last_gnt <= M1;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next state: enter, extend or release a lock; remember the winner.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_nxt    = IDLE;
        hold_cnt_nxt = 8'd0;
        last_gnt_nxt = last_gnt;
        if (gnt[M0])
            last_gnt_nxt = M0;
        else if (gnt[M1])
            last_gnt_nxt = M1;
        case (state)
            IDLE: begin
                if (gnt[M0] && lock[M0]) begin
                    state_nxt    = OWN0;
                    hold_cnt_nxt = 8'd1;
                end else if (gnt[M1] && lock[M1]) begin
                    state_nxt    = OWN1;
                    hold_cnt_nxt = 8'd1;
                end
            end
            OWN0: begin
                if (gnt[M0] && lock[M0] && (hold_inc < MAX_HOLD_W)) begin
                    state_nxt    = OWN0;
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            OWN1: begin
                if (gnt[M1] && lock[M1] && (hold_inc < MAX_HOLD_W)) begin
                    state_nxt    = OWN1;
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                hold_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Grant: lock owner first, then alternate on a tie, else the lone requester.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (state == OWN0 && req[M0] && hold_ok)
                gnt = 2'b01;
            else if (state == OWN1 && req[M1] && hold_ok)
                gnt = 2'b10;
            else if (req == 2'b11)
                gnt = (last_gnt == M1) ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
    end

endmodule : rr_lock_arb

// File: rtl/mem_port_arbiter.sv
// Shares the single-port program/data RAM between the CPU core (M0) and the
// loader/debug port (M1): arbitrates, muxes the winner onto the RAM port,
// returns read data with a per-master valid one cycle later, and counts
// cycles in which some request had to wait.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0] contention_cnt
);

    logic [1:0]          req;
    logic [1:0]          lock;
    logic [1:0]          gnt;
    logic [1:0]          rvalid_q;
    logic                contention;
    logic                ram_we_mux;
    logic [ADDR_LEN-1:0] ram_addr_mux;
    logic [DATA_W-1:0]   ram_wdata_mux;

    assign req  = {bus.m1_req,  bus.m0_req};
    assign lock = {bus.m1_lock, bus.m0_lock};

    rr_lock_arb #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .lock (lock),
        .gnt  (gnt)
    );

    assign bus.m0_gnt = gnt[M0];
    assign bus.m1_gnt = gnt[M1];

    // RAM port mux: winner drives the port, all zero when nobody is granted.
    always_comb begin
        ram_we_mux    = 1'b0;
        ram_addr_mux  = '0;
        ram_wdata_mux = '0;
        if (gnt[M0]) begin
            ram_we_mux    = bus.m0_we;
            ram_addr_mux  = bus.m0_addr;
            ram_wdata_mux = bus.m0_wdata;
        end else if (gnt[M1]) begin
            ram_we_mux    = bus.m1_we;
            ram_addr_mux  = bus.m1_addr;
            ram_wdata_mux = bus.m1_wdata;
        end
    end

    assign bus.ram_we    = ram_we_mux;
    assign bus.ram_addr  = ram_addr_mux;
    assign bus.ram_wdata = ram_wdata_mux;
    assign bus.rdata     = bus.ram_rdata;

    // Read-valid strobes: high exactly one cycle after a granted read.
    always_ff @(posedge clk) begin
        if (rst)
            rvalid_q <= 2'b00;
        else
            rvalid_q <= {gnt[M1] & ~bus.m1_we, gnt[M0] & ~bus.m0_we};
    end

    assign bus.m0_rvalid = rvalid_q[M0];
    assign bus.m1_rvalid = rvalid_q[M1];

    assign contention = (bus.m0_req & ~gnt[M0]) | (bus.m1_req & ~gnt[M1]);

    // Saturating count of cycles where a requester was kept waiting.
    always_ff @(posedge clk) begin
        if (rst)
            contention_cnt <= '0;
        else if (contention && (contention_cnt != '1))
            contention_cnt <= contention_cnt + CNT_W'(1);
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge,
// outputs are sampled 1 ns later, away from the rising edge.
module tb_mem_port_arbiter;

    localparam int ADDR_LEN = 14;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] contention_cnt;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_LEN(ADDR_LEN), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_LEN (ADDR_LEN),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .contention_cnt (contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents as a fixed pattern; word 5 holds 0x1234.
    function automatic logic [31:0] rom(input logic [13:0] a);
        return (a == 14'd5) ? 32'h0000_1234 : {16'hBEEF, 2'b00, a};
    endfunction

    // Synchronous-read RAM model: data appears the cycle after the address.
    always @(posedge clk) bus.ram_rdata <= rom(bus.ram_addr);

    task automatic drive_m0(input logic req, input logic we, input logic lock,
                            input logic [13:0] addr, input logic [31:0] wdata);
        bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
        bus.m0_addr = addr; bus.m0_wdata = wdata;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic lock,
                            input logic [13:0] addr, input logic [31:0] wdata);
        bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
        bus.m1_addr = addr; bus.m1_wdata = wdata;
    endtask

    task automatic idle_all();
        drive_m0(1'b0, 1'b0, 1'b0, 14'd0, 32'd0);
        drive_m1(1'b0, 1'b0, 1'b0, 14'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_m0(1'b1, 1'b1, 1'b1, 14'd3, 32'hDEAD_0000);
        drive_m1(1'b1, 1'b1, 1'b1, 14'd4, 32'hDEAD_0001);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.m0_gnt !== 1'b0) begin errors++; $display("FAIL reset m0_gnt: got %b want 0", bus.m0_gnt); end
        checks++; if (bus.m1_gnt !== 1'b0) begin errors++; $display("FAIL reset m1_gnt: got %b want 0", bus.m1_gnt); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset ram_we: got %b want 0", bus.ram_we); end
        checks++; if (bus.ram_addr !== 14'd0) begin errors++; $display("FAIL reset ram_addr: got %h want 0", bus.ram_addr); end
        checks++; if (bus.ram_wdata !== 32'd0) begin errors++; $display("FAIL reset ram_wdata: got %h want 0", bus.ram_wdata); end
        checks++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset rvalid: got %b%b want 00", bus.m1_rvalid, bus.m0_rvalid); end
        checks++; if (contention_cnt !== 4'd0) begin errors++; $display("FAIL reset contention_cnt: got %0d want 0", contention_cnt); end
        idle_all();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        drive_m0(1'b1, 1'b0, 1'b0, 14'h0005, 32'd0);
        #1;
        checks++; if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin errors++; $display("FAIL single_read gnt: got m1m0=%b%b want 01", bus.m1_gnt, bus.m0_gnt); end
        checks++; if (bus.ram_addr !== 14'h0005 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL single_read ram port: got addr=%h we=%b want 0005/0", bus.ram_addr, bus.ram_we); end
        @(negedge clk);
        bus.m0_req = 1'b0;
        #1;
        checks++; if (bus.m0_rvalid !== 1'b1 || bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL single_read rvalid: got m1m0=%b%b want 01", bus.m1_rvalid, bus.m0_rvalid); end
        checks++; if (bus.rdata !== 32'h0000_1234) begin errors++; $display("FAIL single_read rdata: got %h want 00001234", bus.rdata); end
        checks++; if (contention_cnt !== 4'd0) begin errors++; $display("FAIL single_read contention_cnt: got %0d want 0", contention_cnt); end
        checks++; if (bus.ram_addr !== 14'd0 || bus.m0_gnt !== 1'b0) begin errors++; $display("FAIL single_read idle port: got addr=%h gnt=%b want 0/0", bus.ram_addr, bus.m0_gnt); end
        @(negedge clk);
        #1;
        checks++; if (bus.m0_rvalid !== 1'b0) begin errors++; $display("FAIL single_read rvalid_drop: got %b want 0", bus.m0_rvalid); end
        idle_all();
    endtask

    task automatic test_rr_writes();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic        exp_m1;
            logic [13:0] exp_addr;
            logic [31:0] exp_data;
            @(negedge clk);
            drive_m0(1'b1, 1'b1, 1'b0, 14'd1, 32'hA0 + i);
            drive_m1(1'b1, 1'b1, 1'b0, 14'd2, 32'hB0 + i);
            #1;
            exp_m1   = (i % 2 == 1);
            exp_addr = exp_m1 ? 14'd2 : 14'd1;
            exp_data = exp_m1 ? (32'hB0 + i) : (32'hA0 + i);
            checks++; if (bus.m0_gnt !== ~exp_m1 || bus.m1_gnt !== exp_m1) begin errors++; $display("FAIL rr_writes gnt[%0d]: got m1m0=%b%b want %b%b", i, bus.m1_gnt, bus.m0_gnt, exp_m1, ~exp_m1); end
            checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== exp_addr || bus.ram_wdata !== exp_data) begin errors++; $display("FAIL rr_writes port[%0d]: got we=%b addr=%h data=%h want 1/%h/%h", i, bus.ram_we, bus.ram_addr, bus.ram_wdata, exp_addr, exp_data); end
        end
        @(negedge clk);
        idle_all();
        #1;
        checks++; if (contention_cnt !== 4'd4) begin errors++; $display("FAIL rr_writes contention_cnt: got %0d want 4", contention_cnt); end
        checks++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL rr_writes rvalid: got %b%b want 00", bus.m1_rvalid, bus.m0_rvalid); end
    endtask

    task automatic test_burst_lock();
        do_reset();
        // One lone M0 access so M1 wins the first contested cycle.
        @(negedge clk);
        drive_m0(1'b1, 1'b0, 1'b0, 14'd7, 32'd0);
        #1;
        checks++; if (bus.m0_gnt !== 1'b1) begin errors++; $display("FAIL burst_lock pre gnt: got %b want 1", bus.m0_gnt); end
        for (int i = 0; i < 12; i++) begin
            logic exp_m1;
            @(negedge clk);
            drive_m0(1'b1, 1'b0, 1'b0, 14'd7, 32'd0);
            drive_m1(1'b1, 1'b0, 1'b1, 14'd9, 32'd0);
            #1;
            exp_m1 = (i != 8);
            checks++; if (bus.m1_gnt !== exp_m1 || bus.m0_gnt !== ~exp_m1) begin errors++; $display("FAIL burst_lock gnt[cycle %0d]: got m1m0=%b%b want %b%b", i + 1, bus.m1_gnt, bus.m0_gnt, exp_m1, ~exp_m1); end
        end
        @(negedge clk);
        idle_all();
        #1;
        checks++; if (contention_cnt !== 4'd12) begin errors++; $display("FAIL burst_lock contention_cnt: got %0d want 12", contention_cnt); end
        checks++; if (bus.m1_rvalid !== 1'b1 || bus.rdata !== 32'hBEEF_0009) begin errors++; $display("FAIL burst_lock rdata: got v=%b d=%h want 1/beef0009", bus.m1_rvalid, bus.rdata); end
    endtask

    task automatic test_lock_release();
        bit l0_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bit l1_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit m1_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            logic exp_m1;
            @(negedge clk);
            drive_m0(1'b1, 1'b1, l0_tab[i], 14'd16, 32'h100 + i);
            drive_m1(1'b1, 1'b1, l1_tab[i], 14'd32, 32'h200 + i);
            #1;
            exp_m1 = m1_tab[i];
            checks++; if (bus.m1_gnt !== exp_m1 || bus.m0_gnt !== ~exp_m1) begin errors++; $display("FAIL lock_release gnt[%0d]: got m1m0=%b%b want %b%b", i, bus.m1_gnt, bus.m0_gnt, exp_m1, ~exp_m1); end
            checks++; if (bus.ram_addr !== (exp_m1 ? 14'd32 : 14'd16)) begin errors++; $display("FAIL lock_release addr[%0d]: got %h want %h", i, bus.ram_addr, exp_m1 ? 14'd32 : 14'd16); end
        end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_m1(1'b1, 1'b0, 1'b0, 14'd9, 32'd0);
        #1;
        checks++; if (bus.m1_gnt !== 1'b1) begin errors++; $display("FAIL reset_mid read gnt: got %b want 1", bus.m1_gnt); end
        @(negedge clk);
        rst = 1'b1;
        drive_m0(1'b1, 1'b1, 1'b0, 14'd3, 32'hCAFE_F00D);
        #1;
        checks++; if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_mid gnt: got m1m0=%b%b want 00", bus.m1_gnt, bus.m0_gnt); end
        checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 14'd0 || bus.ram_wdata !== 32'd0) begin errors++; $display("FAIL reset_mid port: got we=%b addr=%h data=%h want 0/0/0", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        @(negedge clk);
        rst = 1'b0;
        drive_m0(1'b1, 1'b0, 1'b0, 14'd5, 32'd0);
        drive_m1(1'b1, 1'b0, 1'b0, 14'd9, 32'd0);
        #1;
        checks++; if (bus.m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_mid m1_rvalid: got %b want 0", bus.m1_rvalid); end
        checks++; if (contention_cnt !== 4'd0) begin errors++; $display("FAIL reset_mid contention_cnt: got %0d want 0", contention_cnt); end
        checks++; if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_mid tie gnt: got m1m0=%b%b want 01", bus.m1_gnt, bus.m0_gnt); end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 19; i++) begin
            logic [3:0] exp_cnt;
            @(negedge clk);
            drive_m0(1'b1, 1'b0, 1'b0, 14'd1, 32'd0);
            drive_m1(1'b1, 1'b0, 1'b0, 14'd2, 32'd0);
            #1;
            exp_cnt = (i > 15) ? 4'hF : 4'(i);
            checks++; if (contention_cnt !== exp_cnt) begin errors++; $display("FAIL saturation cnt[%0d]: got %0d want %0d", i, contention_cnt, exp_cnt); end
        end
        @(negedge clk);
        idle_all();
        #1;
        checks++; if (contention_cnt !== 4'hF) begin errors++; $display("FAIL saturation final: got %0d want 15", contention_cnt); end
        @(negedge clk);
        #1;
        checks++; if (contention_cnt !== 4'hF) begin errors++; $display("FAIL saturation hold: got %0d want 15", contention_cnt); end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_read();
        test_rr_writes();
        test_burst_lock();
        test_lock_release();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data RAM between two masters: M0, the CPU core, and M1, the program loader/debug port.
- Per-cycle round-robin arbitration, with an optional bounded lock for bursts.
- Muxes the winner onto the RAM port and returns read data one cycle later with a per-master valid strobe.
- Sits between the masters and the RAM. Also counts contention cycles for performance debug.

Parameters:
- ADDR_LEN, 14: RAM word-address width.
- DATA_W, 32: data width.
- MAX_HOLD, 8: maximum consecutive locked grants to one master (range 2..255).
- CNT_W, 16: width of the contention counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  M0 requests an access this cycle
- m0_we  in  1  M0 write enable (0 = read)
- m0_addr  in  ADDR_LEN  M0 address
- m0_wdata  in  DATA_W  M0 write data
- m0_lock  in  1  M0 requests to keep ownership next cycle
- m0_gnt  out  1  M0 access performed this cycle (combinational)
- m0_rvalid  out  1  M0 read data valid (registered)
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid: same as M0, for M1
- rdata  out  DATA_W  read data, shared by both masters; qualify with mX_rvalid
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_LEN  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented
- contention_cnt  out  CNT_W  saturating count of cycles in which a request was not granted

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock.
  - Registered state: state=IDLE, last_gnt=M1 (so M0 wins the first tie), hold_cnt=0, m0_rvalid=m1_rvalid=0, contention_cnt=0.
  - While rst is high: m0_gnt=m1_gnt=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Reset mid-transaction drops any pending rvalid; no RAM write occurs in the reset cycle.
- Grant is combinational from the current requests and registered state. The granted access hits the RAM in the same cycle. mX_gnt is one-hot or zero.
- States:
  - IDLE: plain arbitration.
  - OWN0 / OWN1: lock held by M0 / M1.
- Arbitration:
  - In OWNx, if mX_req=1 and hold_cnt<MAX_HOLD: grant x, regardless of the other master.
  - Otherwise, if both masters request, grant the master that is not last_gnt.
  - Otherwise, grant the single requester.
  - With no requester, grant none.
- RAM mux: the winner's we/addr/wdata drive the RAM port. With no grant, all RAM outputs are 0 (never a spurious write).
- Registered updates on every granted cycle:
  - last_gnt <= winner.
  - mX_rvalid <= gnt_x & ~we_x, so it is high exactly one cycle after a granted read.
- rdata = ram_rdata, passed through combinationally.
- State transitions:
  - IDLE -> OWNx when x is granted with mX_lock=1; hold_cnt <= 1.
  - OWNx -> OWNx when x is granted again with lock still high and hold_cnt+1<MAX_HOLD; hold_cnt increments.
  - OWNx -> IDLE when any of these holds: x not requesting; lock low on the granted cycle; hold_cnt reaches MAX_HOLD (forced release). hold_cnt <= 0 on leaving.
  - After a forced release, last_gnt=x, so a waiting other master wins the next cycle. If the other master is idle, x may be regranted and relock; the counter restarts at 1.
- A lock request from a master that is not granted is ignored.
- contention_cnt: increments by 1 in any cycle where (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt). It saturates at all-ones and never wraps.
- Latency:
  - Write: committed in the grant cycle.
  - Read: data is available one cycle after the grant.
  - Maximum wait for a requester: MAX_HOLD+1 cycles.

Decomposition:
- Shared package (cpu_mem_pkg): ADDR_LEN/DATA_W defaults, arbiter state encoding (IDLE=0, OWN0=1, OWN1=2), master index constants M0=0 and M1=1.
- One sub-module: rr_lock_arb. It holds the state, last_gnt and hold_cnt, and produces the grant vector from req/lock. The datapath mux, rvalid registers and counter stay in the top level.

Test Plan:
- After reset, m0_req (read, addr 0x0005) alone, RAM[5]=0x1234 -> m0_gnt=1 same cycle, ram_addr=0x0005, m0_rvalid=1 with rdata=0x1234 next cycle, contention_cnt=0.
- Both masters request writes for 4 cycles, no lock (M0 to addr 1, M1 to addr 2) -> grants M0,M1,M0,M1; ram_we=1 each cycle; contention_cnt=4.
- M1 locks a burst (req+lock held 12 cycles) while M0 requests continuously, MAX_HOLD=8 -> M1 granted 8 consecutive cycles, M0 granted on cycle 9, M1 relocks on cycle 10.
- M0 locks and then drops lock while M1 waits -> M1 granted on the cycle after the unlocked grant.
- rst asserted the cycle after M1's granted read -> m1_rvalid=0, grants 0, ram_we=0; after release, last_gnt=M1, so a tie goes to M0.
- Force contention for 2^CNT_W+3 cycles (CNT_W=4 in bench) -> contention_cnt stays at 0xF.
